// File: rtl/hsstl_pipe_pkg.sv
// Shared PIPE RX definitions: symbol codes, rxstatus encodings,
// symbol-lock FSM encoding, counter widths and the status-merge helper.
package hsstl_pipe_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // COM
  localparam logic [7:0] K28_0 = 8'h1C;  // SKP
  localparam logic [7:0] K30_7 = 8'hFE;  // EDB

  localparam logic [2:0] RXSTAT_OK      = 3'b000;
  localparam logic [2:0] RXSTAT_DEC_ERR = 3'b100;
  localparam logic [2:0] RXSTAT_OVF     = 3'b101;
  localparam logic [2:0] RXSTAT_UNF     = 3'b110;
  localparam logic [2:0] RXSTAT_DISP    = 3'b111;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // Wide enough for the default thresholds (4 COMs, 4 errors, 16-word window).
  localparam int COM_CNT_W  = 3;
  localparam int ERR_CNT_W  = 3;
  localparam int GOOD_CNT_W = 5;

  // One pclk worth of receive data as it arrives from upstream.
  typedef struct packed {
    logic [2:0]  status;
    logic [3:0]  datak;
    logic [31:0] data;
  } rx_word_t;

  // A rotated word straddles two input words; report the worst condition
  // of either, ranked decode > overflow > underflow > disparity.
  function automatic logic [2:0] merge_status(input logic [2:0] prev_s,
                                              input logic [2:0] cur_s);
    if (prev_s == RXSTAT_DEC_ERR || cur_s == RXSTAT_DEC_ERR) return RXSTAT_DEC_ERR;
    if (prev_s == RXSTAT_OVF     || cur_s == RXSTAT_OVF)     return RXSTAT_OVF;
    if (prev_s == RXSTAT_UNF     || cur_s == RXSTAT_UNF)     return RXSTAT_UNF;
    if (prev_s == RXSTAT_DISP    || cur_s == RXSTAT_DISP)    return RXSTAT_DISP;
    return prev_s;
  endfunction

endpackage

// File: rtl/hsstl_rx_byte_rotate.sv
// Combinational byte/K selector: picks four consecutive bytes starting at
// byte 'ofs' out of a 64-bit window (bytes 0-3 older word, 4-7 newer word).
module hsstl_rx_byte_rotate (
  input  logic [63:0] win_data,
  input  logic [7:0]  win_datak,
  input  logic [1:0]  ofs,
  output logic [31:0] rot_data,
  output logic [3:0]  rot_datak
);

  // 4:1 mux selecting the aligned byte group and its K flags.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    rot_data  = win_data[31:0];
    rot_datak = win_datak[3:0];
    case (ofs)
      2'd1: begin
        rot_data  = win_data[39:8];
        rot_datak = win_datak[4:1];
      end
      2'd2: begin
        rot_data  = win_data[47:16];
        rot_datak = win_datak[5:2];
      end
      2'd3: begin
        rot_data  = win_data[55:24];
        rot_datak = win_datak[6:3];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hsstl_phy_mac_rx_sym_align.sv
// PIPE RX symbol aligner: locates COM within the 4-symbol word, rotates the
// stream so COM sits on lane0, and runs the symbol-lock FSM that gates
// pipe_rxvalid. Data and status flow in every state; only rxvalid is gated.
module hsstl_phy_mac_rx_sym_align
  import hsstl_pipe_pkg::*;
#(
  parameter int LOCK_COM_CNT   = 4,
  parameter int UNLOCK_ERR_CNT = 4,
  parameter int GOOD_WIN       = 16
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic [2:0]  rx_status,
  input  logic        rx_elec_idle,
  output logic [31:0] pipe_rxdata,
  output logic [3:0]  pipe_rxdatak,
  output logic [2:0]  pipe_rxstatus,
  output logic        pipe_rxvalid,
  output logic        sym_lock,
  output logic [1:0]  align_ofs
);

  localparam logic [COM_CNT_W-1:0]  LOCK_CNT_C   = COM_CNT_W'(LOCK_COM_CNT);
  localparam logic [ERR_CNT_W-1:0]  UNLOCK_CNT_C = ERR_CNT_W'(UNLOCK_ERR_CNT);
  localparam logic [GOOD_CNT_W-1:0] GOOD_LAST_C  = GOOD_CNT_W'(GOOD_WIN - 1);

  rx_word_t               cur, prev_q;
  lock_state_e            state_q, state_d;
  logic [1:0]             align_ofs_q, align_ofs_d;
  logic [COM_CNT_W-1:0]   com_cnt_q, com_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [GOOD_CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [31:0]            rxdata_q, rot_data;
  logic [3:0]             rxdatak_q, rot_datak;
  logic [2:0]             rxstatus_q, rxstatus_d;
  logic                   rxvalid_q;

  logic                   com_hit;
  logic [1:0]             com_lane;
  logic                   err_word;
  logic                   bad_word;

  assign cur = {rx_status, rx_datak, rx_data};

  // Lowest lane of the held word carrying a K28.5; scanning downward lets the lowest hit win.
  always_comb begin
    com_hit  = 1'b0;
    com_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (prev_q.datak[i] && prev_q.data[8*i +: 8] == K28_5) begin
        com_hit  = 1'b1;
        com_lane = 2'(i);
      end
    end
  end

  assign err_word = (prev_q.status == RXSTAT_DEC_ERR) || (prev_q.status == RXSTAT_DISP);
  assign bad_word = err_word || (com_hit && com_lane != align_ofs_q);

  // Symbol-lock next-state and counter logic, judged on the held word.
  always_comb begin
    state_d     = state_q;
    align_ofs_d = align_ofs_q;
    com_cnt_d   = com_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    if (rx_elec_idle) begin
      state_d    = ST_UNLOCKED;
      com_cnt_d  = '0;
      err_cnt_d  = '0;
      good_cnt_d = '0;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          if (com_hit) begin
            state_d     = ST_CHECK;
            align_ofs_d = com_lane;
            com_cnt_d   = COM_CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (err_word) begin
            state_d   = ST_UNLOCKED;
            com_cnt_d = '0;
          end else if (com_hit && com_lane != align_ofs_q) begin
            // COM moved: restart the count at the new position.
            align_ofs_d = com_lane;
            com_cnt_d   = COM_CNT_W'(1);
          end else if (com_hit) begin
            com_cnt_d = com_cnt_q + COM_CNT_W'(1);
            if (com_cnt_d == LOCK_CNT_C) begin
              state_d    = ST_LOCKED;
              err_cnt_d  = '0;
              good_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (bad_word) begin
            good_cnt_d = '0;
            if (err_cnt_q != UNLOCK_CNT_C) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (err_cnt_d == UNLOCK_CNT_C) begin
              state_d    = ST_UNLOCKED;
              com_cnt_d  = '0;
              err_cnt_d  = '0;
              good_cnt_d = '0;
            end
          end else if (good_cnt_q == GOOD_LAST_C) begin
            // A full clean window forgives one earlier error.
            good_cnt_d = '0;
            if (err_cnt_q != '0) err_cnt_d = err_cnt_q - ERR_CNT_W'(1);
          end else begin
            good_cnt_d = good_cnt_q + GOOD_CNT_W'(1);
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  // Rotation follows the offset being written this edge, so a new
  // alignment is visible in the very word that established it.
  hsstl_rx_byte_rotate u_rotate (
    .win_data  ({cur.data, prev_q.data}),
    .win_datak ({cur.datak, prev_q.datak}),
    .ofs       (align_ofs_d),
    .rot_data  (rot_data),
    .rot_datak (rot_datak)
  );

  // Status for the output word: straight through when aligned, merged when straddling.
  always_comb begin
    rxstatus_d = prev_q.status;
    if (align_ofs_d != 2'd0) rxstatus_d = merge_status(prev_q.status, cur.status);
  end

  // All state and output registers; the held word is cleared too so nothing stale leaks out after reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      state_q     <= ST_UNLOCKED;
      align_ofs_q <= 2'd0;
      com_cnt_q   <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      rxdata_q    <= '0;
      rxdatak_q   <= '0;
      rxstatus_q  <= '0;
      rxvalid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, matching the hardware.
      prev_q      <= cur;
      state_q     <= state_d;
      align_ofs_q <= align_ofs_d;
      com_cnt_q   <= com_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      rxdata_q    <= rot_data;
      rxdatak_q   <= rot_datak;
      rxstatus_q  <= rxstatus_d;
      rxvalid_q   <= (state_d == ST_LOCKED);
    end
  end

  assign pipe_rxdata   = rxdata_q;
  assign pipe_rxdatak  = rxdatak_q;
  assign pipe_rxstatus = rxstatus_q;
  assign pipe_rxvalid  = rxvalid_q;
  assign sym_lock      = rxvalid_q;
  assign align_ofs     = align_ofs_q;

endmodule
